// File: rtl/lifo_stack_if.sv
// lifo_stack_if
// Bundles the producer/consumer side of a lifo_stack into one port.
//   master : drives clear, push, pop, din; observes dout, count and flags
//   slave  : the stack itself, the mirror image of master
// CW is derived from DEPTH here so the count width always agrees with the
// stack instance that uses the same DEPTH.
interface lifo_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, push, pop, din,
    input  dout, count, empty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  clear, push, pop, din,
    output dout, count, empty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack
// Parametrised LIFO with same-cycle push+pop (top replace), occupancy,
// almost-full and sticky overflow/underflow flags.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (empties stack, clears flags)
//   bus   : lifo_stack_if.slave carrying clear/push/pop/din in and
//           dout/count/empty/full/almost_full/overflow/underflow out
// The storage array has no reset; count is the only control state, so the
// top entry lives at count-1 and the next free slot at count.
module lifo_stack #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input logic         clk,
  input logic         reset,
  lifo_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  logic             isEmpty;
  logic             isFull;
  logic [CW-1:0]    topFull;
  logic [AW-1:0]    topIdx;
  logic [AW-1:0]    wrIdx;
  logic             wrEn;

  // Index math is done at full count width and only then narrowed. The
  // narrowing is lossless because a write slot (count when not full) or a
  // top slot (count-1 when not empty) is always below DEPTH, so nothing
  // aliases even when DEPTH is not a power of two.
  always_comb begin
    isEmpty = (count == '0);
    isFull  = (count == CW'(DEPTH));
    topFull = count - CW'(1);
    topIdx  = topFull[AW-1:0];
    wrEn    = !bus.clear && bus.push && (bus.pop || !isFull);
    wrIdx   = (bus.pop && !isEmpty) ? topIdx : count[AW-1:0];
  end

  // Storage: a plain push writes the free slot, a push+pop on a non-empty
  // stack overwrites the top, and a push+pop on an empty stack lands in
  // slot 0 (which is count, so the same path covers it).
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= din_q();
    end
  end

  function automatic logic [WIDTH-1:0] din_q();
    return bus.din;
  endfunction

  // Control state: clear dominates, then the {push,pop} decode. Rejected
  // operations leave count alone and latch the matching sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({bus.push, bus.pop})
        2'b10: begin
          if (!isFull) count <= count + CW'(1);
          else         overflow <= 1'b1;
        end
        2'b01: begin
          if (!isEmpty) count <= count - CW'(1);
          else          underflow <= 1'b1;
        end
        2'b11: begin
          if (isEmpty) count <= CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status decode; dout is forced to zero when empty so the unreset array
  // never leaks onto the output.
  always_comb begin
    bus.count       = count;
    bus.empty       = isEmpty;
    bus.full        = isFull;
    bus.almost_full = (count >= CW'(AFULL_LEVEL));
    bus.overflow    = overflow;
    bus.underflow   = underflow;
    bus.dout        = isEmpty ? '0 : mem[topIdx];
  end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack
// Directed checks of an 8x8 stack (default parameters) plus a 5x12 stack
// with AFULL_LEVEL=3, the latter also run against a small reference model.
module tb_lifo_stack;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  lifo_stack_if #(.WIDTH(8),  .DEPTH(8)) bA ();
  lifo_stack_if #(.WIDTH(12), .DEPTH(5)) bB ();

  lifo_stack #(.WIDTH(8), .DEPTH(8)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (bA.slave)
  );

  lifo_stack #(.WIDTH(12), .DEPTH(5), .AFULL_LEVEL(3)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (bB.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it; inputs also change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveA(input logic c, input logic ps, input logic pp, input logic [7:0] d);
    bA.clear = c; bA.push = ps; bA.pop = pp; bA.din = d;
  endtask

  task automatic driveB(input logic c, input logic ps, input logic pp, input logic [11:0] d);
    bB.clear = c; bB.push = ps; bB.pop = pp; bB.din = d;
  endtask

  // Reset state, then an asynchronous reset in the middle of a cycle with a
  // push pending and the underflow flag set.
  task automatic test_reset();
    logic [8:0] gotA;
    reset = 1'b1;
    driveA(0, 0, 0, 8'h00);
    driveB(0, 0, 0, 12'h000);
    step(); step();
    reset = 1'b0;
    step();
    gotA = {bA.count, bA.empty, bA.full, bA.almost_full, bA.overflow, bA.underflow};
    checks++;
    if (gotA !== 9'b0000_1_0_0_0_0) begin
      $display("[TB] FAIL reset_state_A got=%b expected=%b", gotA, 9'b000010000); errors++;
    end
    checks++;
    if (bA.dout !== 8'h00) begin
      $display("[TB] FAIL reset_dout_A got=%h expected=00", bA.dout); errors++;
    end
    checks++;
    if ({bB.count, bB.empty, bB.full, bB.almost_full, bB.dout} !== {3'd0, 3'b100, 12'h000}) begin
      $display("[TB] FAIL reset_state_B got=%h expected=%h",
               {bB.count, bB.empty, bB.full, bB.almost_full, bB.dout}, {3'd0, 3'b100, 12'h000});
      errors++;
    end
    driveA(0, 0, 1, 8'h00);
    step();
    driveA(0, 1, 0, 8'h42);
    step();
    checks++;
    if ({bA.count, bA.dout, bA.underflow} !== {4'd1, 8'h42, 1'b1}) begin
      $display("[TB] FAIL pre_reset got cnt=%0d dout=%h unf=%b expected cnt=1 dout=42 unf=1",
               bA.count, bA.dout, bA.underflow);
      errors++;
    end
    // push still asserted; reset mid-cycle
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bA.count, bA.empty, bA.dout, bA.overflow, bA.underflow} !== {4'd0, 1'b1, 8'h00, 2'b00}) begin
      $display("[TB] FAIL async_reset got cnt=%0d empty=%b dout=%h ovf=%b unf=%b expected cnt=0 empty=1 dout=00 flags=00",
               bA.count, bA.empty, bA.dout, bA.overflow, bA.underflow);
      errors++;
    end
    driveA(0, 0, 0, 8'h00);
    #1 reset = 1'b0;
    step();
    checks++;
    if ({bA.count, bA.empty} !== {4'd0, 1'b1}) begin
      $display("[TB] FAIL post_reset_idle got cnt=%0d empty=%b expected cnt=0 empty=1", bA.count, bA.empty);
      errors++;
    end
  endtask

  // Push 0x11..0x88 on consecutive cycles.
  task automatic test_fill();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 8'((i + 1) * 8'h11);
      driveA(0, 1, 0, v);
      step();
      checks++;
      if ({bA.count, bA.dout, bA.almost_full, bA.full, bA.empty} !==
          {4'(i + 1), v, (i + 1 >= 7), (i + 1 == 8), 1'b0}) begin
        $display("[TB] FAIL fill_%0d got cnt=%0d dout=%h af=%b full=%b empty=%b expected cnt=%0d dout=%h af=%b full=%b empty=0",
                 i, bA.count, bA.dout, bA.almost_full, bA.full, bA.empty, i + 1, v, (i + 1 >= 7), (i + 1 == 8));
        errors++;
      end
    end
    driveA(0, 0, 0, 8'h00);
  endtask

  // Rejected push on a full stack, then a top replace while full.
  task automatic test_overflow();
    driveA(0, 1, 0, 8'hAA);
    step();
    checks++;
    if ({bA.overflow, bA.underflow, bA.count, bA.dout} !== {2'b10, 4'd8, 8'h88}) begin
      $display("[TB] FAIL overflow_push got ovf=%b unf=%b cnt=%0d dout=%h expected ovf=1 unf=0 cnt=8 dout=88",
               bA.overflow, bA.underflow, bA.count, bA.dout);
      errors++;
    end
    driveA(0, 1, 1, 8'hBB);
    step();
    checks++;
    if ({bA.overflow, bA.underflow, bA.count, bA.dout, bA.full} !== {2'b10, 4'd8, 8'hBB, 1'b1}) begin
      $display("[TB] FAIL full_replace got ovf=%b unf=%b cnt=%0d dout=%h full=%b expected ovf=1 unf=0 cnt=8 dout=BB full=1",
               bA.overflow, bA.underflow, bA.count, bA.dout, bA.full);
      errors++;
    end
    driveA(0, 0, 0, 8'h00);
  endtask

  // Eight pops: BB (replaced top), then 77 down to 11, then empty.
  task automatic test_drain();
    logic [7:0] expTop;
    for (int i = 0; i < 8; i++) begin
      expTop = (i == 0) ? 8'hBB : 8'((8 - i) * 8'h11);
      checks++;
      if (bA.dout !== expTop) begin
        $display("[TB] FAIL drain_top_%0d got=%h expected=%h", i, bA.dout, expTop); errors++;
      end
      driveA(0, 0, 1, 8'h00);
      step();
      checks++;
      if (bA.count !== 4'(7 - i)) begin
        $display("[TB] FAIL drain_cnt_%0d got=%0d expected=%0d", i, bA.count, 7 - i); errors++;
      end
    end
    driveA(0, 0, 0, 8'h00);
    checks++;
    if ({bA.empty, bA.dout, bA.almost_full, bA.overflow} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      $display("[TB] FAIL drain_end got empty=%b dout=%h af=%b ovf=%b expected empty=1 dout=00 af=0 ovf=1",
               bA.empty, bA.dout, bA.almost_full, bA.overflow);
      errors++;
    end
  endtask

  // Rejected pop on empty, then push+pop on empty acting as a push.
  task automatic test_underflow();
    driveA(0, 0, 1, 8'h00);
    step();
    checks++;
    if ({bA.underflow, bA.overflow, bA.count} !== {2'b11, 4'd0}) begin
      $display("[TB] FAIL underflow_pop got unf=%b ovf=%b cnt=%0d expected unf=1 ovf=1 cnt=0",
               bA.underflow, bA.overflow, bA.count);
      errors++;
    end
    driveA(0, 1, 1, 8'h5C);
    step();
    checks++;
    if ({bA.count, bA.dout, bA.underflow, bA.overflow} !== {4'd1, 8'h5C, 2'b11}) begin
      $display("[TB] FAIL empty_pushpop got cnt=%0d dout=%h unf=%b ovf=%b expected cnt=1 dout=5C unf=1 ovf=1",
               bA.count, bA.dout, bA.underflow, bA.overflow);
      errors++;
    end
    driveA(0, 0, 0, 8'h00);
  endtask

  // Clear with push at count=3 and both flags set: everything flushed.
  task automatic test_clear();
    driveA(0, 1, 0, 8'h01);
    step();
    driveA(0, 1, 0, 8'h02);
    step();
    checks++;
    if ({bA.count, bA.dout, bA.overflow, bA.underflow} !== {4'd3, 8'h02, 2'b11}) begin
      $display("[TB] FAIL clear_pre got cnt=%0d dout=%h ovf=%b unf=%b expected cnt=3 dout=02 ovf=1 unf=1",
               bA.count, bA.dout, bA.overflow, bA.underflow);
      errors++;
    end
    driveA(1, 1, 0, 8'hEE);
    step();
    checks++;
    if ({bA.count, bA.empty, bA.dout, bA.overflow, bA.underflow} !== {4'd0, 1'b1, 8'h00, 2'b00}) begin
      $display("[TB] FAIL clear_push got cnt=%0d empty=%b dout=%h ovf=%b unf=%b expected cnt=0 empty=1 dout=00 flags=00",
               bA.count, bA.empty, bA.dout, bA.overflow, bA.underflow);
      errors++;
    end
    driveA(0, 0, 0, 8'h00);
  endtask

  // Interleaved push/pop/replace every cycle with no idle gaps.
  task automatic test_back_to_back();
    logic [1:0]  op   [6] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01};
    logic [7:0]  din  [6] = '{8'h31, 8'h32, 8'h3F, 8'h00, 8'h34, 8'h00};
    logic [3:0]  eCnt [6] = '{4'd1,  4'd2,  4'd2,  4'd1,  4'd2,  4'd1};
    logic [7:0]  eTop [6] = '{8'h31, 8'h32, 8'h3F, 8'h31, 8'h34, 8'h31};
    for (int i = 0; i < 6; i++) begin
      driveA(0, op[i][1], op[i][0], din[i]);
      step();
      checks++;
      if ({bA.count, bA.dout} !== {eCnt[i], eTop[i]}) begin
        $display("[TB] FAIL b2b_%0d got cnt=%0d dout=%h expected cnt=%0d dout=%h",
                 i, bA.count, bA.dout, eCnt[i], eTop[i]);
        errors++;
      end
    end
    driveA(0, 0, 0, 8'h00);
  endtask

  // DEPTH=5 WIDTH=12 AFULL_LEVEL=3: fill, drain, refill.
  task automatic test_small_config();
    logic [11:0] v;
    for (int i = 0; i < 5; i++) begin
      v = 12'hA01 + 12'(i);
      driveB(0, 1, 0, v);
      step();
      checks++;
      if ({bB.count, bB.dout, bB.almost_full, bB.full} !== {3'(i + 1), v, (i + 1 >= 3), (i + 1 == 5)}) begin
        $display("[TB] FAIL small_fill_%0d got cnt=%0d dout=%h af=%b full=%b expected cnt=%0d dout=%h af=%b full=%b",
                 i, bB.count, bB.dout, bB.almost_full, bB.full, i + 1, v, (i + 1 >= 3), (i + 1 == 5));
        errors++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      v = 12'hA05 - 12'(i);
      checks++;
      if (bB.dout !== v) begin
        $display("[TB] FAIL small_drain_%0d got=%h expected=%h", i, bB.dout, v); errors++;
      end
      driveB(0, 0, 1, 12'h000);
      step();
    end
    checks++;
    if ({bB.count, bB.empty, bB.dout, bB.overflow, bB.underflow} !== {3'd0, 1'b1, 12'h000, 2'b00}) begin
      $display("[TB] FAIL small_empty got cnt=%0d empty=%b dout=%h ovf=%b unf=%b expected cnt=0 empty=1 dout=000 flags=00",
               bB.count, bB.empty, bB.dout, bB.overflow, bB.underflow);
      errors++;
    end
    driveB(0, 1, 0, 12'h7E1);
    step();
    driveB(0, 1, 0, 12'h7E2);
    step();
    checks++;
    if ({bB.count, bB.dout, bB.almost_full} !== {3'd2, 12'h7E2, 1'b0}) begin
      $display("[TB] FAIL small_refill got cnt=%0d dout=%h af=%b expected cnt=2 dout=7E2 af=0",
               bB.count, bB.dout, bB.almost_full);
      errors++;
    end
    driveB(0, 0, 0, 12'h000);
  endtask

  // Random traffic on the 5-deep stack against a reference stack.
  task automatic test_random_small();
    logic [11:0] mm [5];
    int          mc;
    logic        mo, mu;
    logic        c, ps, pp;
    logic [11:0] d;
    logic [11:0] eTop;
    logic [19:0] got, exp;
    driveB(1, 0, 0, 12'h000);
    step();
    mc = 0; mo = 1'b0; mu = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      c  = ($urandom_range(0, 31) == 0);
      ps = 1'($urandom_range(0, 1));
      pp = 1'($urandom_range(0, 1));
      d  = 12'($urandom_range(0, 4095));
      driveB(c, ps, pp, d);
      if (c) begin
        mc = 0; mo = 1'b0; mu = 1'b0;
      end else if (ps && !pp) begin
        if (mc < 5) begin mm[mc] = d; mc++; end
        else mo = 1'b1;
      end else if (!ps && pp) begin
        if (mc > 0) mc--;
        else mu = 1'b1;
      end else if (ps && pp) begin
        if (mc == 0) begin mm[0] = d; mc = 1; end
        else mm[mc - 1] = d;
      end
      step();
      eTop = (mc == 0) ? 12'h000 : mm[mc - 1];
      exp  = {3'(mc), eTop, (mc == 0), (mc == 5), (mc >= 3), mo, mu};
      got  = {bB.count, bB.dout, bB.empty, bB.full, bB.almost_full, bB.overflow, bB.underflow};
      checks++;
      if (got !== exp) begin
        $display("[TB] FAIL random_%0d got=%h expected=%h", n, got, exp); errors++;
      end
    end
    driveB(0, 0, 0, 12'h000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_clear();
    test_back_to_back();
    test_small_config();
    test_random_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised last-in first-out stack with configurable data width and depth. Supports a same-cycle push+pop (top replace) and exposes occupancy, almost-full, and sticky overflow/underflow error flags. Sits between a producer and a consumer that need reverse-order buffering, such as expression evaluation, return-address storage or undo buffers. It is the general-purpose successor to the fixed 8x8 stack.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries (>=2; need not be a power of two)
- AFULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH)
- CW (localparam), $clog2(DEPTH+1), width of count

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush: empties the stack and clears the error flags
- push  in  1  write din onto the stack
- pop  in  1  remove the top entry
- din  in  WIDTH  data to push
- dout  out  WIDTH  current top of stack (combinational); 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_LEVEL
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- **Storage:** DEPTH x WIDTH register array with no reset.
- **State:** the only control state is count. Top entry index is count-1, and the next write index is count.
- **Priority per cycle:** clear, then the operation decoded from {push, pop}.
- **clear=1:**
  - count <= 0; overflow <= 0; underflow <= 0.
  - push and pop are ignored and the memory is unchanged.
- **push only, not full:** mem[count] <= din; count <= count+1.
- **push only, full:**
  - Memory and count are unchanged.
  - overflow <= 1.
- **pop only, not empty:** count <= count-1. Memory is unchanged.
- **pop only, empty:**
  - count is unchanged.
  - underflow <= 1.
- **push+pop, not empty (including full):**
  - Replace the top: mem[count-1] <= din.
  - count is unchanged.
  - No error flag is set.
- **push+pop, empty:**
  - Behaves as a push: mem[0] <= din; count <= 1.
  - No underflow.
- **Neither:** hold.
- **Sticky flags:** overflow and underflow remain set until clear or reset. Further errors keep them at 1.
- **Arithmetic:** count is unsigned CW bits and never wraps. Bounds are enforced by the rules above. Index arithmetic must not alias when DEPTH is not a power of two.
- **Derived outputs:** empty, full and almost_full are decoded combinationally from count. dout = empty ? 0 : mem[count-1].

## Timing
- **Reset (asynchronous, immediate on reset rising):**
  - count = 0, so empty = 1, full = 0, almost_full = 0.
  - overflow = 0, underflow = 0, dout = 0.
- **Reset mid-operation:** an in-flight push is abandoned. After release the stack is empty; memory contents are don't-care.
- **Operation latency:** every operation takes effect at the sampling clock edge. count, the flags and dout reflect the new state in the following cycle.
- **Push:** a value pushed at edge N is visible on dout immediately after edge N.
- **Top replace:** after a push+pop at edge N, dout shows the new din after edge N.
- **Back-to-back:** pushes and pops are accepted every cycle with no bubbles.
- **Gating:** full and empty seen by the caller in cycle N describe the state that gates the operation sampled at the end of cycle N.
- **Error flags:** overflow/underflow assert in the cycle after the offending edge.

## Test plan
1. Reset asserted asynchronously mid-cycle -> count=0, empty=1, dout=0 and both flags 0 before the next clk edge.
2. DEPTH=8: push 0x11..0x88 on 8 consecutive cycles -> count steps 1..8, almost_full rises at count=7, full=1 at 8; then 8 pops -> dout reads 0x88, 0x77, …, 0x11, then empty=1 and dout=0.
3. Full stack: push 0xAA alone -> overflow=1, count stays 8, top still 0x88. Then push+pop with 0xBB -> top=0xBB, count=8, overflow still 1.
4. Empty stack: pop alone -> underflow=1, count=0. Then push+pop with 0x5C -> count=1, dout=0x5C, with no change to the flags.
5. Count=3 with overflow and underflow both set: clear asserted together with push -> count=0, both flags 0, and the push is ignored.
6. DEPTH=5, WIDTH=12, AFULL_LEVEL=3: fill to 5, pop to 0 and refill, with random push/pop for 1000 cycles -> every cycle matches a reference stack model on count, dout, flags, no index aliasing.
